// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the RS5 data-bus arbiter and the SoC top.
// The address decode lives here so the SoC top and the arbiter agree on the memory map.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        SLV_RAM  = 2'd0,
        SLV_RTC  = 2'd1,
        SLV_PLIC = 2'd2,
        SLV_TB   = 2'd3
    } slave_e;

    localparam logic [3:0] RTC_BASE_DEF  = 4'h2;
    localparam logic [3:0] PLIC_BASE_DEF = 4'h3;
    localparam logic [3:0] TB_BASE_DEF   = 4'h8;

    // Maps the top address nibble onto a slave using ascending region thresholds.
    function automatic slave_e decode_slave(input logic [3:0] region,
                                            input logic [3:0] rtc_base,
                                            input logic [3:0] plic_base,
                                            input logic [3:0] tb_base);
        slave_e slv;
        if (region < rtc_base) begin
            slv = SLV_RAM;
        end else if (region < plic_base) begin
            slv = SLV_RTC;
        end else if (region < tb_base) begin
            slv = SLV_PLIC;
        end else begin
            slv = SLV_TB;
        end
        return slv;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way bus grant logic. Grants are combinational; last_q remembers the most
// recent winner so that ties alternate. Reset leaves last_q at m1 so m0 wins the first tie.
module bus_rr_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_q;

    // Pick a winner this cycle: a lone requester always wins, ties go by policy.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (FIXED_PRIO != 0 || last_q) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    // Remember who was granted most recently; idle cycles keep the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (gnt0) begin
            last_q <= 1'b0;
        end else if (gnt1) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data bus between the RS5 core (m0) and a DMA/debug master (m1),
// decodes the granted address onto RAM/RTC/PLIC/TB and steers the one-cycle-late
// read data back to whichever master issued the read.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int         FIXED_PRIO = 0,
    parameter logic [3:0] RTC_BASE   = RTC_BASE_DEF,
    parameter logic [3:0] PLIC_BASE  = PLIC_BASE_DEF,
    parameter logic [3:0] TB_BASE    = TB_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_en_i,
    input  logic [3:0]  m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_data_o,
    input  logic        m1_en_i,
    input  logic [3:0]  m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_data_o,
    output logic        ram_en_o,
    output logic        rtc_en_o,
    output logic        plic_en_o,
    output logic        tb_en_o,
    output logic [3:0]  s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] ram_data_i,
    input  logic [31:0] rtc_data_i,
    input  logic [31:0] plic_data_i,
    input  logic [31:0] tb_data_i
);

    logic        gnt0;
    logic        gnt1;
    logic        gnt_any;
    slave_e      slave;
    slave_e      sel_q;
    logic        owner_q;
    logic        rd_q;
    logic        rsp_live;
    logic [31:0] rsp_data;

    bus_rr_arbiter #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (m0_en_i),
        .req1  (m1_en_i),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign gnt_any  = gnt0 | gnt1;
    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // Forward the winner's request to the slaves; an idle bus is driven to zero.
    always_comb begin
        s_we_o   = 4'h0;
        s_addr_o = 32'h0;
        s_data_o = 32'h0;
        if (gnt0) begin
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
        end else if (gnt1) begin
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
        end
    end

    // One-hot slave select from the granted address, all low when nobody is granted.
    always_comb begin
        slave     = decode_slave(s_addr_o[31:28], RTC_BASE, PLIC_BASE, TB_BASE);
        ram_en_o  = 1'b0;
        rtc_en_o  = 1'b0;
        plic_en_o = 1'b0;
        tb_en_o   = 1'b0;
        if (gnt_any) begin
            case (slave)
                SLV_RAM:  ram_en_o  = 1'b1;
                SLV_RTC:  rtc_en_o  = 1'b1;
                SLV_PLIC: plic_en_o = 1'b1;
                default:  tb_en_o   = 1'b1;
            endcase
        end
    end

    // Capture which slave answers next cycle, for whom, and whether it is a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= SLV_RAM;
            owner_q <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            sel_q   <= slave;
            owner_q <= gnt1;
            rd_q    <= gnt_any && (s_we_o == 4'h0);
        end
    end

    // Route the registered slave's read data to its owner; reset squashes any pending response.
    always_comb begin
        rsp_live = rd_q && !reset;
        case (sel_q)
            SLV_RAM:  rsp_data = ram_data_i;
            SLV_RTC:  rsp_data = rtc_data_i;
            SLV_PLIC: rsp_data = plic_data_i;
            default:  rsp_data = tb_data_i;
        endcase
        m0_rvalid_o = rsp_live && !owner_q;
        m1_rvalid_o = rsp_live && owner_q;
        m0_data_o   = m0_rvalid_o ? rsp_data : 32'h0;
        m1_data_o   = m1_rvalid_o ? rsp_data : 32'h0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a round-robin instance and a
// fixed-priority instance share all inputs and are compared against a
// transaction-level model (who wins, which address range, what comes back next cycle).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_en, m1_en;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [31:0] ram_rd, rtc_rd, plic_rd, tb_rd;

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, rtc_en, plic_en, tb_en;
    logic [3:0]  s_we;
    logic [31:0] s_addr, s_data;

    logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_ram_en, fp_rtc_en, fp_plic_en, fp_tb_en;
    logic [3:0]  fp_s_we;
    logic [31:0] fp_s_addr, fp_s_data;

    int n_checks = 0;
    int n_fail   = 0;

    int rr_last, rr_pend, rr_owner, rr_slave;
    int fp_pend, fp_owner, fp_slave;
    int g_rr, g_fp;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_en_i(m0_en), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_data_o(m0_rdata),
        .m1_en_i(m1_en), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_data_o(m1_rdata),
        .ram_en_o(ram_en), .rtc_en_o(rtc_en), .plic_en_o(plic_en), .tb_en_o(tb_en),
        .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_data),
        .ram_data_i(ram_rd), .rtc_data_i(rtc_rd), .plic_data_i(plic_rd), .tb_data_i(tb_rd)
    );

    mem_bus_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_en_i(m0_en), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rvalid), .m0_data_o(fp_m0_rdata),
        .m1_en_i(m1_en), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rvalid), .m1_data_o(fp_m1_rdata),
        .ram_en_o(fp_ram_en), .rtc_en_o(fp_rtc_en), .plic_en_o(fp_plic_en), .tb_en_o(fp_tb_en),
        .s_we_o(fp_s_we), .s_addr_o(fp_s_addr), .s_data_o(fp_s_data),
        .ram_data_i(ram_rd), .rtc_data_i(rtc_rd), .plic_data_i(plic_rd), .tb_data_i(tb_rd)
    );

    // Memory map by plain address ranges: 0 = RAM, 1 = RTC, 2 = PLIC, 3 = TB.
    function automatic int slave_of(input logic [31:0] a);
        if (a < 32'h2000_0000) return 0;
        if (a < 32'h3000_0000) return 1;
        if (a < 32'h8000_0000) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] slave_word(input int s);
        case (s)
            0:       return ram_rd;
            1:       return rtc_rd;
            2:       return plic_rd;
            default: return tb_rd;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One bus cycle: drive inputs after the falling edge, check both DUTs
    // against the model, then advance the model as the rising edge will.
    task automatic applyStimulus(input logic rst,
                                 input logic e0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic e1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1);
        logic [3:0]  exp_en;
        logic [3:0]  exp_we;
        logic [31:0] exp_addr, exp_data;
        logic        rv0, rv1, frv0, frv1;
        @(negedge clk);
        reset = rst;
        m0_en = e0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_en = e1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        if (e0 && e1) g_rr = (rr_last == 0) ? 1 : 0;
        else if (e0)  g_rr = 0;
        else if (e1)  g_rr = 1;
        else          g_rr = -1;
        g_fp = e0 ? 0 : (e1 ? 1 : -1);

        exp_we   = (g_rr == 0) ? w0 : (g_rr == 1) ? w1 : 4'h0;
        exp_addr = (g_rr == 0) ? a0 : (g_rr == 1) ? a1 : 32'h0;
        exp_data = (g_rr == 0) ? d0 : (g_rr == 1) ? d1 : 32'h0;
        exp_en   = (g_rr >= 0) ? 4'(1 << slave_of(exp_addr)) : 4'h0;

        checkOutput("m0_gnt", 32'(m0_gnt), 32'(g_rr == 0));
        checkOutput("m1_gnt", 32'(m1_gnt), 32'(g_rr == 1));
        checkOutput("slave_en", 32'({tb_en, plic_en, rtc_en, ram_en}), 32'(exp_en));
        checkOutput("s_we", 32'(s_we), 32'(exp_we));
        checkOutput("s_addr", s_addr, exp_addr);
        checkOutput("s_data", s_data, exp_data);

        rv0 = !rst && rr_pend != 0 && rr_owner == 0;
        rv1 = !rst && rr_pend != 0 && rr_owner == 1;
        checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
        checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
        checkOutput("m0_rdata", m0_rdata, rv0 ? slave_word(rr_slave) : 32'h0);
        checkOutput("m1_rdata", m1_rdata, rv1 ? slave_word(rr_slave) : 32'h0);

        frv0 = !rst && fp_pend != 0 && fp_owner == 0;
        frv1 = !rst && fp_pend != 0 && fp_owner == 1;
        checkOutput("fp_m0_gnt", 32'(fp_m0_gnt), 32'(g_fp == 0));
        checkOutput("fp_m1_gnt", 32'(fp_m1_gnt), 32'(g_fp == 1));
        checkOutput("fp_m0_rdata", fp_m0_rdata, frv0 ? slave_word(fp_slave) : 32'h0);
        checkOutput("fp_m1_rdata", fp_m1_rdata, frv1 ? slave_word(fp_slave) : 32'h0);
        checkOutput("fp_rvalid", 32'({fp_m1_rvalid, fp_m0_rvalid}), 32'({frv1, frv0}));

        if (rst) begin
            rr_last = 1; rr_pend = 0; fp_pend = 0;
        end else begin
            if (g_rr >= 0) rr_last = g_rr;
            rr_pend  = (g_rr >= 0 && exp_we == 4'h0) ? 1 : 0;
            rr_owner = g_rr;
            rr_slave = slave_of(exp_addr);
            fp_pend  = (g_fp == 0) ? ((w0 == 4'h0) ? 1 : 0) : (g_fp == 1) ? ((w1 == 4'h0) ? 1 : 0) : 0;
            fp_owner = g_fp;
            fp_slave = (g_fp == 0) ? slave_of(a0) : slave_of(a1);
        end
    endtask

    task automatic idleCycle(input logic rst);
        applyStimulus(rst, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic        h0_en, h1_en;
        logic [3:0]  h0_we, h1_we;
        logic [31:0] h0_addr, h1_addr, h0_data, h1_data;
        logic [31:0] bounds [4];
        int          last_g;

        rr_last = 1; rr_pend = 0; rr_owner = 0; rr_slave = 0;
        fp_pend = 0; fp_owner = 0; fp_slave = 0;
        reset = 1'b1;
        m0_en = 1'b0; m0_we = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_en = 1'b0; m1_we = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        ram_rd = 32'hDEADBEEF; rtc_rd = 32'h12345678; plic_rd = 32'h00000007; tb_rd = 32'hCAFEF00D;

        idleCycle(1'b1);
        idleCycle(1'b1);
        idleCycle(1'b0);
        checkOutput("reset_m0_rvalid", 32'(m0_rvalid), 32'h0);
        checkOutput("reset_m0_rdata", m0_rdata, 32'h0);

        // Single m0 read from RAM.
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("rd_ram_en", 32'(ram_en), 32'h1);
        idleCycle(1'b0);
        checkOutput("rd_ram_data", m0_rdata, 32'hDEADBEEF);
        checkOutput("rd_ram_m1_quiet", 32'({m1_rvalid, m1_gnt}) | m1_rdata, 32'h0);

        // Continuous tie after reset: round-robin alternates starting with m0.
        idleCycle(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0200, 32'h0, 1'b1, 4'h0, 32'h0000_0300, 32'h0);
            checkOutput("tie_alternate", 32'(m1_gnt), 32'(i % 2));
            checkOutput("tie_fixed_m1_never", 32'(fp_m1_gnt), 32'h0);
        end
        idleCycle(1'b0);

        // Decode boundaries: RAM, RTC, PLIC, TB.
        bounds[0] = 32'h1FFF_FFFC; bounds[1] = 32'h2000_0000;
        bounds[2] = 32'h7FFF_FFFF; bounds[3] = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h0, bounds[i], 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
            checkOutput("boundary_en", 32'({tb_en, plic_en, rtc_en, ram_en}), 32'(4'b0001 << i));
        end
        idleCycle(1'b0);
        checkOutput("boundary_tb_data", m0_rdata, 32'hCAFEF00D);

        // m1 write to the TB region produces no response.
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h8000_1000, 32'h41);
        checkOutput("wr_tb_en", 32'({tb_en, s_we}), 32'h1F);
        checkOutput("wr_s_data", s_data, 32'h41);
        idleCycle(1'b0);
        checkOutput("wr_no_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);

        // Back-to-back: m0 reads RTC, then m1 reads PLIC.
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h2000_0010, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h3000_0000, 32'h0);
        checkOutput("b2b_m0_data", m0_rdata, 32'h12345678);
        checkOutput("b2b_m1_idle", m1_rdata, 32'h0);
        idleCycle(1'b0);
        checkOutput("b2b_m1_data", m1_rdata, 32'h7);
        checkOutput("b2b_m0_idle", m0_rdata, 32'h0);

        // Reset right after a granted read squashes the response and restores m0 tie priority.
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        idleCycle(1'b1);
        checkOutput("rst_mid_rvalid", 32'(m0_rvalid), 32'h0);
        idleCycle(1'b0);
        checkOutput("rst_after_rvalid", 32'(m0_rvalid), 32'h0);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        checkOutput("rst_tie_m0", 32'(m0_gnt), 32'h1);

        // Random traffic; an ungranted request is held until the round-robin DUT grants it.
        h0_en = 1'b0; h1_en = 1'b0;
        h0_we = 4'h0; h1_we = 4'h0;
        h0_addr = 32'h0; h1_addr = 32'h0; h0_data = 32'h0; h1_data = 32'h0;
        last_g = -1;
        for (int i = 0; i < 400; i++) begin
            if (!h0_en || last_g == 0) begin
                h0_en   = 1'($urandom_range(0, 1));
                h0_we   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                h0_addr = $urandom;
                h0_data = $urandom;
            end
            if (!h1_en || last_g == 1) begin
                h1_en   = 1'($urandom_range(0, 1));
                h1_we   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                h1_addr = $urandom;
                h1_data = $urandom;
            end
            ram_rd = $urandom; rtc_rd = $urandom; plic_rd = $urandom; tb_rd = $urandom;
            applyStimulus(($urandom_range(0, 39) == 0), h0_en, h0_we, h0_addr, h0_data,
                          h1_en, h1_we, h1_addr, h1_data);
            last_g = g_rr;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
